psum_fifo: RTL

PSUM_FIFO -- requirements
Module: psum_fifo

---
 rtl/psum_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/psum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : psum_fifo
// Purpose  : Partial-sum beat FIFO between the Local Network bus and the
//            consumer (bus side or GLB). First-word fall-through from
//            storage, registered ready, pass-length tracking with a one-cycle
//            done pulse and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module psum_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int PSUM_NUM  = 4,
  parameter int DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_info,
  input  logic [7:0]                        pass_len,
  input  logic                              clear,
  input  logic [PSUM_NUM*DATA_SIZE:0]       in_beat,
  output logic                              in_ready,
  output logic [PSUM_NUM*DATA_SIZE:0]       out_beat,
  input  logic                              out_ready,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              pass_done,
  output logic                              overflow
);

  localparam int c_DW = PSUM_NUM * DATA_SIZE;
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [c_DW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_live;       // low until the first edge after reset release
  logic            r_ovf;
  logic [7:0]      r_pass_len;
  logic [7:0]      r_pass_cnt;
  logic            r_pass_done;

  logic            w_in_en;
  logic [c_DW-1:0] w_in_data;
  logic            w_out_en;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_pass_next;

  assign w_in_en   = in_beat[c_DW];
  assign w_in_data = in_beat[c_DW-1:0];

  // Ready comes only from registered state; no path from out_ready.
  assign in_ready  = r_live && (r_count != c_FULL);
  assign w_out_en  = (r_count != '0);
  assign w_push    = w_in_en && in_ready;
  assign w_pop     = w_out_en && out_ready;
  assign w_pass_next = r_pass_cnt + 8'd1;

  // Empty FIFO drives an all-zero bus so stale storage never leaks out.
  assign out_beat  = w_out_en ? {1'b1, r_mem[r_rptr]} : '0;
  assign count     = r_count;
  assign pass_done = r_pass_done;
  assign overflow  = r_ovf;

  // Storage write; contents are not reset or flushed, only pointers are.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wptr] <= w_in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky overflow: a beat offered while not ready is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_in_en && !in_ready) begin
      r_ovf <= 1'b1;
    end
  end

  // Pass tracking: set_info beats a pop; a zero length disables counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass_len  <= 8'd0;
      r_pass_cnt  <= 8'd0;
      r_pass_done <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      if (clear) begin
        r_pass_cnt <= 8'd0;
      end else if (set_info) begin
        r_pass_len <= pass_len;
        r_pass_cnt <= 8'd0;
      end else if (w_pop && (r_pass_len != 8'd0)) begin
        if (w_pass_next == r_pass_len) begin
          r_pass_cnt  <= 8'd0;
          r_pass_done <= 1'b1;
        end else begin
          r_pass_cnt <= w_pass_next;
        end
      end
    end
  end

endmodule
`default_nettype wire
